// File: rtl/riscv_pkg.sv
// Shared definitions for the 5-stage core: hazard FSM state encoding and
// E-stage forwarding mux select codes.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2,
        ST_ERROR    = 2'd3
    } hz_state_t;

    localparam logic [1:0] FWD_RF = 2'b00;  // operand from register file
    localparam logic [1:0] FWD_W  = 2'b01;  // operand from W-stage result
    localparam logic [1:0] FWD_M  = 2'b10;  // operand from M-stage ALU result

endpackage

// File: rtl/hazard_controller_forward_sel.sv
// Forwarding source select for one E-stage operand. The M stage holds the
// younger result and therefore wins over W; x0 is hard-wired zero and is
// never forwarded.
module forward_sel
    import riscv_pkg::*;
(
    input  logic [4:0] rs_e,
    input  logic [4:0] rd_m,
    input  logic [4:0] rd_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output logic [1:0] fwd_sel
);

    // Compare the E source against M then W destinations.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_write_m && (rd_m != 5'd0) && (rd_m == rs_e)) begin
            fwd_sel = FWD_M;
        end else if (reg_write_w && (rd_w != 5'd0) && (rd_w == rs_e)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Central hazard/sequencing controller. Produces stall/flush controls for the
// pipeline registers and E-stage forwarding selects. Handles load-use and
// taken-branch hazards, data-memory wait states with a timeout watchdog, a
// post-reset boot flush, and a saturating stall-cycle performance counter.
// Only the FSM state and counters are registered; all outputs are
// combinational from state and inputs.
module hazard_controller
    import riscv_pkg::*;
#(
    parameter int BOOT_CYCLES = 2,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             LoadE,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             dmem_ready,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam int BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);
    // Last wait count before the watchdog fires (only meaningful when enabled).
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    hz_state_t         state_reg, state_next;
    logic [BOOT_W-1:0] boot_cnt_reg, boot_cnt_next;
    logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
    logic [CNT_W-1:0]  stall_cycles_reg, stall_cycles_next;

    logic       lw_stall;
    logic       mem_stall;
    logic       active;
    logic [4:0] fwd_rs_e [2];
    logic [1:0] fwd_sel  [2];

    assign fwd_rs_e[0] = Rs1E;
    assign fwd_rs_e[1] = Rs2E;

    // One forwarding comparator per E-stage operand (A, B).
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            forward_sel u_forward_sel (
                .rs_e        (fwd_rs_e[gi]),
                .rd_m        (RdM),
                .rd_w        (RdW),
                .reg_write_m (RegWriteM),
                .reg_write_w (RegWriteW),
                .fwd_sel     (fwd_sel[gi])
            );
        end
    endgenerate

    assign active    = (state_reg == ST_RUN) || (state_reg == ST_MEM_WAIT);
    assign lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign mem_stall = MemReqM && !dmem_ready;

    // State and counter registers; async active-low reset returns to BOOT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg        <= ST_BOOT;
            boot_cnt_reg     <= '0;
            wait_cnt_reg     <= '0;
            stall_cycles_reg <= '0;
        end else begin
            state_reg        <= state_next;
            boot_cnt_reg     <= boot_cnt_next;
            wait_cnt_reg     <= wait_cnt_next;
            stall_cycles_reg <= stall_cycles_next;
        end
    end

    // Next-state logic: boot sequencing, memory wait tracking and watchdog.
    always_comb begin
        state_next    = state_reg;
        boot_cnt_next = boot_cnt_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_BOOT: begin
                if (boot_cnt_reg >= BOOT_LAST) begin
                    state_next    = ST_RUN;
                    boot_cnt_next = '0;
                end else begin
                    boot_cnt_next = boot_cnt_reg + 1'b1;
                end
            end
            ST_RUN: begin
                if (mem_stall) begin
                    state_next    = ST_MEM_WAIT;
                    wait_cnt_next = WAIT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                // A completing access wins over the watchdog on the threshold cycle.
                if (dmem_ready) begin
                    state_next    = ST_RUN;
                    wait_cnt_next = '0;
                end else if ((MEM_TIMEOUT != 0) && (wait_cnt_reg >= WAIT_LAST)) begin
                    state_next = ST_ERROR;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_cnt_next = wait_cnt_reg + 1'b1;
                end
            end
            ST_ERROR: begin
                state_next = ST_ERROR;
            end
            default: begin
                state_next = ST_ERROR;
            end
        endcase
    end

    // Pipeline control outputs; a memory stall freezes everything and defers
    // branch/load-use handling until the access completes.
    always_comb begin
        StallF      = 1'b0;
        StallD      = 1'b0;
        StallE      = 1'b0;
        StallM      = 1'b0;
        FlushD      = 1'b0;
        FlushE      = 1'b0;
        FlushW      = 1'b0;
        ForwardAE   = FWD_RF;
        ForwardBE   = FWD_RF;
        mem_timeout = 1'b0;
        case (state_reg)
            ST_BOOT: begin
                StallF = 1'b1;
                FlushD = 1'b1;
                FlushE = 1'b1;
                FlushW = 1'b1;
            end
            ST_RUN, ST_MEM_WAIT: begin
                ForwardAE = fwd_sel[0];
                ForwardBE = fwd_sel[1];
                if (mem_stall) begin
                    StallF = 1'b1;
                    StallD = 1'b1;
                    StallE = 1'b1;
                    StallM = 1'b1;
                    FlushW = 1'b1;
                end else begin
                    StallF = lw_stall;
                    StallD = lw_stall;
                    FlushD = PCSrcE;
                    FlushE = lw_stall || PCSrcE;
                end
            end
            default: begin
                StallF      = 1'b1;
                StallD      = 1'b1;
                StallE      = 1'b1;
                StallM      = 1'b1;
                mem_timeout = 1'b1;
            end
        endcase
    end

    // Saturating count of fetch-stall cycles while the pipeline is running.
    always_comb begin
        stall_cycles_next = stall_cycles_reg;
        if (active && StallF && (stall_cycles_reg != {CNT_W{1'b1}})) begin
            stall_cycles_next = stall_cycles_reg + 1'b1;
        end
    end

    assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller (BOOT_CYCLES=2, MEM_TIMEOUT=4).
// Inputs change 1 time unit after each rising edge; outputs are sampled 1 unit
// later, well clear of the next edge.
module tb_hazard_controller;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [4:0]  Rs1D = '0, Rs2D = '0, Rs1E = '0, Rs2E = '0;
    logic [4:0]  RdE = '0, RdM = '0, RdW = '0;
    logic        LoadE = 1'b0, RegWriteM = 1'b0, RegWriteW = 1'b0;
    logic        PCSrcE = 1'b0, MemReqM = 1'b0, dmem_ready = 1'b0;
    logic        StallF, StallD, StallE, StallM;
    logic        FlushD, FlushE, FlushW;
    logic [1:0]  ForwardAE, ForwardBE;
    logic        mem_timeout;
    logic [15:0] stall_cycles;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    hazard_controller #(
        .BOOT_CYCLES (2),
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .Rs1D         (Rs1D),
        .Rs2D         (Rs2D),
        .Rs1E         (Rs1E),
        .Rs2E         (Rs2E),
        .RdE          (RdE),
        .RdM          (RdM),
        .RdW          (RdW),
        .LoadE        (LoadE),
        .RegWriteM    (RegWriteM),
        .RegWriteW    (RegWriteW),
        .PCSrcE       (PCSrcE),
        .MemReqM      (MemReqM),
        .dmem_ready   (dmem_ready),
        .StallF       (StallF),
        .StallD       (StallD),
        .StallE       (StallE),
        .StallM       (StallM),
        .FlushD       (FlushD),
        .FlushE       (FlushE),
        .FlushW       (FlushW),
        .ForwardAE    (ForwardAE),
        .ForwardBE    (ForwardBE),
        .mem_timeout  (mem_timeout),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d t=%0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Packed view of the seven stall/flush outputs: {StallF,D,E,M,FlushD,E,W}.
    function automatic int ctl();
        return int'({StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW});
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        {Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW} = '0;
        {LoadE, RegWriteM, RegWriteW, PCSrcE, MemReqM, dmem_ready} = '0;
    endtask

    task automatic release_and_boot(input string tag);
        next_cycle();
        reset = 1'b1;
        settle();
        check({tag, "_boot0_ctl"}, ctl(), 7'b1000111);
        next_cycle();
        settle();
        check({tag, "_boot1_ctl"}, ctl(), 7'b1000111);
        next_cycle();
        settle();
        check({tag, "_run_ctl"}, ctl(), 7'b0000000);
        check({tag, "_run_cnt"}, int'(stall_cycles), 0);
    endtask

    initial begin
        // Held in reset: BOOT outputs, counter clear.
        repeat (2) next_cycle();
        check("rst_ctl", ctl(), 7'b1000111);
        check("rst_fwd", int'({ForwardAE, ForwardBE}), 0);
        check("rst_cnt", int'(stall_cycles), 0);
        check("rst_timeout", int'(mem_timeout), 0);

        release_and_boot("a");

        // Forwarding
        RdM = 5; RdW = 5; Rs1E = 5; RegWriteM = 1; RegWriteW = 1; settle();
        check("fwdA_M", int'(ForwardAE), 2);
        RdM = 0; settle();
        check("fwdA_W", int'(ForwardAE), 1);
        Rs2E = 0; RdW = 0; settle();
        check("fwdB_x0", int'(ForwardBE), 0);
        RdW = 9; Rs2E = 9; RdM = 9; RegWriteM = 0; settle();
        check("fwdB_W_noM", int'(ForwardBE), 1);
        check("fwdA_none", int'(ForwardAE), 0);
        clear_inputs();

        // Load-use stall
        next_cycle();
        LoadE = 1; RdE = 7; Rs2D = 7; settle();
        check("lw_ctl", ctl(), 7'b1100010);
        next_cycle();
        clear_inputs(); settle();
        check("lw_after_ctl", ctl(), 7'b0000000);
        check("lw_cnt", int'(stall_cycles), 1);
        LoadE = 1; RdE = 0; Rs2D = 0; Rs1D = 0; settle();
        check("lw_x0_ctl", ctl(), 7'b0000000);
        next_cycle();
        check("lw_x0_cnt", int'(stall_cycles), 1);

        // Branch together with load-use
        LoadE = 1; RdE = 7; Rs1D = 7; PCSrcE = 1; settle();
        check("br_lw_ctl", ctl(), 7'b1100110);
        next_cycle();
        clear_inputs(); settle();
        check("br_lw_cnt", int'(stall_cycles), 2);
        PCSrcE = 1; settle();
        check("br_only_ctl", ctl(), 7'b0000110);
        next_cycle();
        clear_inputs();

        // Memory wait: 3 stalled cycles then ready, branch pending throughout
        for (int i = 0; i < 3; i++) begin
            MemReqM = 1; dmem_ready = 0; PCSrcE = 1; settle();
            check($sformatf("mw_stall%0d_ctl", i), ctl(), 7'b1111001);
            next_cycle();
        end
        dmem_ready = 1; settle();
        check("mw_release_ctl", ctl(), 7'b0000110);
        next_cycle();
        clear_inputs(); settle();
        check("mw_cnt", int'(stall_cycles), 5);
        check("mw_ctl_idle", ctl(), 7'b0000000);
        check("mw_timeout", int'(mem_timeout), 0);
        next_cycle();

        // Timeout: 4 stalled cycles with no ready -> ERROR
        for (int i = 0; i < 4; i++) begin
            MemReqM = 1; dmem_ready = 0; settle();
            check($sformatf("to_stall%0d_ctl", i), ctl(), 7'b1111001);
            check($sformatf("to_stall%0d_flag", i), int'(mem_timeout), 0);
            next_cycle();
        end
        RdM = 5; Rs1E = 5; RegWriteM = 1; PCSrcE = 1; settle();
        check("err_flag", int'(mem_timeout), 1);
        check("err_ctl", ctl(), 7'b1111000);
        check("err_fwd", int'(ForwardAE), 0);
        MemReqM = 0; dmem_ready = 1;
        next_cycle();
        next_cycle();
        check("err_sticky_flag", int'(mem_timeout), 1);
        check("err_sticky_ctl", ctl(), 7'b1111000);
        check("err_cnt_hold", int'(stall_cycles), 9);
        clear_inputs();

        // Reset out of ERROR is immediate
        #2 reset = 1'b0; #1;
        check("err_rst_flag", int'(mem_timeout), 0);
        check("err_rst_cnt", int'(stall_cycles), 0);
        check("err_rst_ctl", ctl(), 7'b1000111);
        release_and_boot("b");

        // Reset asserted in the middle of a memory wait
        MemReqM = 1; dmem_ready = 0;
        next_cycle();
        next_cycle();
        check("mid_wait_ctl", ctl(), 7'b1111001);
        check("mid_wait_cnt", int'(stall_cycles), 2);
        #2 reset = 1'b0; #1;
        check("mid_rst_ctl", ctl(), 7'b1000111);
        check("mid_rst_cnt", int'(stall_cycles), 0);
        clear_inputs();
        release_and_boot("c");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        failures++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
